// File: rtl/if_stage.sv
// Instruction fetch with one-outstanding variable-latency imem port and IF/ID register; 1 instr/cycle with zero-wait memory.
// Stall parks a returning word in a one-entry skid buffer (HOLD); a redirect with a fetch in flight drains it first (DRAIN).
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        inst_valid
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_reg, pc_nxt;
  logic [31:0] addr_q, addr_nxt;
  logic [31:0] buf_q, buf_nxt;
  logic [31:0] bpc_q, bpc_nxt;
  logic [31:0] addr_inc;
  logic        load;
  logic [31:0] load_pc;
  logic [31:0] load_inst;

  assign addr_inc  = addr_q + 32'd4;
  assign imem_req  = rst_n && (state != HOLD);
  assign imem_addr = addr_q;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_reg;
    addr_nxt  = addr_q;
    buf_nxt   = buf_q;
    bpc_nxt   = bpc_q;
    load      = 1'b0;
    load_pc   = 32'd0;
    load_inst = NOP_INST;
    case (state)
      FETCH: begin
        if (imem_valid) begin
          if (redirect) begin
            pc_nxt   = redirect_pc;
            addr_nxt = redirect_pc;
          end else if (stall) begin
            buf_nxt   = imem_rdata;
            bpc_nxt   = addr_inc;
            pc_nxt    = addr_inc;
            state_nxt = HOLD;
          end else begin
            load      = 1'b1;
            load_pc   = addr_inc;
            load_inst = imem_rdata;
            pc_nxt    = addr_inc;
            addr_nxt  = addr_inc;
          end
        end else if (redirect) begin
          // addr_q must stay on the in-flight address until memory answers
          pc_nxt    = redirect_pc;
          state_nxt = DRAIN;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_nxt    = redirect_pc;
          addr_nxt  = redirect_pc;
          state_nxt = FETCH;
        end else if (!stall) begin
          load      = 1'b1;
          load_pc   = bpc_q;
          load_inst = buf_q;
          addr_nxt  = pc_reg;
          state_nxt = FETCH;
        end
      end
      DRAIN: begin
        if (redirect) begin
          pc_nxt = redirect_pc;
        end
        if (imem_valid) begin
          addr_nxt  = pc_nxt;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= FETCH;
      pc_reg <= RESET_PC;
      addr_q <= RESET_PC;
      buf_q  <= NOP_INST;
      bpc_q  <= 32'd0;
    end else begin
      state  <= state_nxt;
      pc_reg <= pc_nxt;
      addr_q <= addr_nxt;
      buf_q  <= buf_nxt;
      bpc_q  <= bpc_nxt;
    end
  end

  // IF/ID register: flush beats stall, stall beats load/bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_out     <= 32'd0;
      inst_out   <= NOP_INST;
      inst_valid <= 1'b0;
    end else if (flush) begin
      pc_out     <= 32'd0;
      inst_out   <= NOP_INST;
      inst_valid <= 1'b0;
    end else if (!stall) begin
      pc_out     <= load_pc;
      inst_out   <= load_inst;
      inst_valid <= load;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus randomized stall/redirect/latency against a program-order scoreboard.
module tb_if_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        inst_valid;

  int total = 0;
  int bad   = 0;

  // memory model state: one outstanding request, rdata = address
  bit          mem_busy;
  int          mem_cnt;
  int          mem_lat;
  bit          mem_rand;
  logic [31:0] mem_addr;

  if_stage #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .pc_out(pc_out), .inst_out(inst_out), .inst_valid(inst_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic mem_step();
    if (rst_n && imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_addr = imem_addr;
        mem_cnt  = mem_rand ? int'($urandom_range(0, 3)) : mem_lat - 1;
      end else begin
        check("addr_stable", imem_addr, mem_addr);
      end
      if (mem_cnt == 0) begin
        imem_valid = 1'b1;
        imem_rdata = mem_addr;
        mem_busy   = 1'b0;
      end else begin
        imem_valid = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        mem_cnt--;
      end
    end else begin
      imem_valid = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    mem_step();
  endtask

  task automatic do_reset(input int lat);
    @(negedge clk);
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    mem_busy = 1'b0; mem_rand = 1'b0; mem_lat = lat; imem_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    mem_step();
  endtask

  logic [31:0] exp_next, q_pc, q_inst, p_rpc;
  logic        q_valid, p_stall, p_flush, p_redirect;
  int          entries;

  initial begin
    stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    imem_valid = 1'b0; imem_rdata = 32'd0; mem_busy = 1'b0; mem_rand = 1'b0; mem_lat = 1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_pc", pc_out, 32'd0);
    check("rst_inst", inst_out, NOP);
    check("rst_valid", 32'(inst_valid), 32'd0);

    // zero-wait streaming
    do_reset(1);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      check("t1_inst", inst_out, 32'(4 * (k - 1)));
      check("t1_pc", pc_out, 32'(4 * k));
      check("t1_valid", 32'(inst_valid), 32'd1);
    end

    // latency 3, then redirect while 0x10 is in flight
    do_reset(3);
    for (int k = 1; k <= 12; k++) begin
      cyc();
      check("t2_addr", imem_addr, 32'(4 * (k / 3)));
      check("t2_valid", 32'(inst_valid), 32'((k % 3) == 0));
      if ((k % 3) == 0) check("t2_inst", inst_out, 32'(4 * (k / 3 - 1)));
    end
    redirect = 1'b1; redirect_pc = 32'h40;
    for (int k = 13; k <= 17; k++) begin
      cyc();
      redirect = 1'b0;
      check("t4_addr", imem_addr, (k < 15) ? 32'h10 : 32'h40);
      check("t4_req", 32'(imem_req), 32'd1);
      check("t4_valid", 32'(inst_valid), 32'd0);
    end
    cyc();
    check("t4_inst", inst_out, 32'h40);
    check("t4_pc", pc_out, 32'h44);
    check("t4_ivalid", 32'(inst_valid), 32'd1);

    // stall two cycles while 0x8 returns
    do_reset(1);
    cyc(); cyc();
    stall = 1'b1;
    cyc();
    check("t3_hold1", inst_out, 32'h4);
    check("t3_req", 32'(imem_req), 32'd0);
    cyc();
    check("t3_hold2", inst_out, 32'h4);
    stall = 1'b0;
    cyc();
    check("t3_inst8", inst_out, 32'h8);
    check("t3_pc", pc_out, 32'hC);
    check("t3_addr", imem_addr, 32'hC);
    cyc();
    check("t3_instC", inst_out, 32'hC);

    // flush together with stall
    do_reset(1);
    cyc(); cyc();
    stall = 1'b1; flush = 1'b1;
    cyc();
    check("t5_inst", inst_out, NOP);
    check("t5_valid", 32'(inst_valid), 32'd0);
    check("t5_pc", pc_out, 32'd0);
    stall = 1'b0; flush = 1'b0;
    cyc();
    check("t5_buf", inst_out, 32'h8);

    // reset in the middle of a drain
    do_reset(3);
    cyc(); cyc(); cyc();
    redirect = 1'b1; redirect_pc = 32'h80;
    cyc();
    redirect = 1'b0;
    check("t6_drain_addr", imem_addr, 32'h4);
    #2 rst_n = 1'b0;
    #1;
    check("t6_req", 32'(imem_req), 32'd0);
    check("t6_valid", 32'(inst_valid), 32'd0);
    check("t6_pc", pc_out, 32'd0);
    check("t6_inst", inst_out, NOP);
    mem_busy = 1'b0; imem_valid = 1'b0;
    do_reset(1);
    check("t6_addr", imem_addr, RST_PC);
    check("t6_req1", 32'(imem_req), 32'd1);
    cyc();
    check("t6_first", inst_out, RST_PC);

    // randomized: every word entering IF/ID must follow program order from the latest redirect
    do_reset(1);
    mem_rand = 1'b1;
    exp_next = RST_PC;
    entries  = 0;
    for (int i = 0; i < 3000; i++) begin
      stall       = ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : (32'($urandom_range(0, 255)) << 2);
      flush       = redirect && ($urandom_range(0, 1) == 1);
      p_stall = stall; p_flush = flush; p_redirect = redirect; p_rpc = redirect_pc;
      q_pc = pc_out; q_inst = inst_out; q_valid = inst_valid;
      cyc();
      if (p_redirect) exp_next = p_rpc;
      if (p_flush) begin
        check("r_flush_valid", 32'(inst_valid), 32'd0);
        check("r_flush_inst", inst_out, NOP);
        check("r_flush_pc", pc_out, 32'd0);
      end else if (p_stall) begin
        check("r_stall_pc", pc_out, q_pc);
        check("r_stall_inst", inst_out, q_inst);
        check("r_stall_valid", 32'(inst_valid), 32'(q_valid));
      end else if (inst_valid) begin
        check("r_seq_inst", inst_out, exp_next);
        check("r_seq_pc", pc_out, exp_next + 32'd4);
        exp_next = exp_next + 32'd4;
        entries++;
      end else begin
        check("r_bubble", inst_out, NOP);
      end
    end
    check("r_progress", 32'(entries >= 100), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
